// File: rtl/mem_pkg.sv
// Shared definitions for the main memory responder: FSM states, access
// direction encodings and default sizing constants.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_e;

   localparam logic MRW_READ  = 1'b0;
   localparam logic MRW_WRITE = 1'b1;

   localparam int DEFAULT_ADDR_W      = 8;
   localparam int DEFAULT_DATA_W      = 8;
   localparam int DEFAULT_WAIT_CYCLES = 4;

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable wait-state down-counter; counts toward zero and reports when it
// holds 1, which marks the final wait cycle of an access.
module mem_wait_ctr (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       last
);

   logic [7:0] count_q, count_d;

   // Saturates at zero so an idle counter never raises last spuriously.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != 8'd0) begin
         count_d = count_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == 8'd1);

endmodule

// File: rtl/main_mem_responder.sv
// Main memory model answering single-word cache requests after a fixed number
// of wait states; one access in flight at a time, extra strobes are dropped.
module main_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MStrobe,
   input  logic              MRW,
   input  logic [ADDR_W-1:0] MAddr,
   input  logic [DATA_W-1:0] MDataIn,
   output logic [DATA_W-1:0] MDataOut,
   output logic              MReady,
   output logic              MBusy
);

   localparam int DEPTH = 2 ** ADDR_W;

   mem_state_e        state_q, state_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic ctr_load;
   logic ctr_last;
   logic commit;

   assign ctr_load = (state_q == IDLE) && MStrobe;

   mem_wait_ctr u_wait_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (8'(WAIT_CYCLES)),
      .last     (ctr_last)
   );

   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (MStrobe) begin
               rw_d    = MRW;
               addr_d  = MAddr;
               wdata_d = MDataIn;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (ctr_last) begin
               state_d = DONE;
               if (rw_q == MRW_READ) begin
                  rdata_d = mem[addr_q];
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is deliberately outside reset; an aborted write never commits.
   assign commit = !reset && (state_q == ACCESS) && ctr_last && (rw_q == MRW_WRITE);

   always_ff @(posedge clk) begin
      if (commit) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign MReady   = (state_q == DONE);
   assign MBusy    = (state_q != IDLE);
   assign MDataOut = rdata_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run, all against a plain array model of the memory.
module tb_main_mem_responder;
   import mem_pkg::*;

   localparam int W0 = 4;
   localparam int W1 = 1;

   logic       clk = 1'b0;
   logic       reset0, reset1;
   logic       strobe0, strobe1, rw0, rw1;
   logic [7:0] addr0, addr1, din0, din1, dout0, dout1;
   logic       ready0, ready1, busy0, busy1;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [2][256];
   bit         known [2][256];
   logic [7:0] exp_dout [2];

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   main_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .reset(reset0), .MStrobe(strobe0), .MRW(rw0), .MAddr(addr0),
      .MDataIn(din0), .MDataOut(dout0), .MReady(ready0), .MBusy(busy0)
   );

   main_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .reset(reset1), .MStrobe(strobe1), .MRW(rw1), .MAddr(addr1),
      .MDataIn(din1), .MDataOut(dout1), .MReady(ready1), .MBusy(busy1)
   );

   function automatic logic [7:0] get_dout(input int which);
      return (which == 0) ? dout0 : dout1;
   endfunction

   function automatic logic get_ready(input int which);
      return (which == 0) ? ready0 : ready1;
   endfunction

   function automatic logic get_busy(input int which);
      return (which == 0) ? busy0 : busy1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int which, input logic s, input logic r_w,
                        input logic [7:0] a, input logic [7:0] d);
      if (which == 0) begin
         strobe0 = s; rw0 = r_w; addr0 = a; din0 = d;
      end else begin
         strobe1 = s; rw1 = r_w; addr1 = a; din1 = d;
      end
   endtask

   task automatic setReset(input int which, input logic v);
      if (which == 0) reset0 = v;
      else reset1 = v;
   endtask

   // Called at a negedge; the strobe lands in that cycle (cycle T). Returns at
   // the negedge of the first idle cycle so a following call is back-to-back.
   task automatic applyStimulus(input int which, input logic r_w, input logic [7:0] a,
                                input logic [7:0] d, input int extra_at, input int reset_at);
      int w;
      w = (which == 0) ? W0 : W1;
      drive(which, 1'b1, r_w, a, d);
      for (int k = 1; k <= w + 1; k++) begin
         @(negedge clk);
         if (k == w + 1) begin
            if (r_w == MRW_READ) begin
               exp_dout[which] = ref_mem[which][a];
            end else begin
               ref_mem[which][a] = d;
               known[which][a]   = 1'b1;
            end
         end
         checkOutput("busy_in_access", 32'(get_busy(which)), 32'd1);
         checkOutput("ready_timing", 32'(get_ready(which)), 32'(k == w + 1));
         checkOutput("dout_during_access", 32'(get_dout(which)), 32'(exp_dout[which]));
         drive(which, (k == extra_at), ~r_w, 8'($urandom), 8'($urandom));
         if (k == reset_at) begin
            setReset(which, 1'b1);
            @(negedge clk);
            setReset(which, 1'b0);
            exp_dout[which] = 8'h00;
            checkOutput("busy_after_abort", 32'(get_busy(which)), 32'd0);
            checkOutput("ready_after_abort", 32'(get_ready(which)), 32'd0);
            checkOutput("dout_after_abort", 32'(get_dout(which)), 32'd0);
            return;
         end
      end
      @(negedge clk);
      checkOutput("busy_idle", 32'(get_busy(which)), 32'd0);
      checkOutput("ready_idle", 32'(get_ready(which)), 32'd0);
      checkOutput("dout_idle", 32'(get_dout(which)), 32'(exp_dout[which]));
   endtask

   initial begin
      logic       r_w;
      logic [7:0] a;
      int         extra;

      for (int i = 0; i < 256; i++) begin
         known[0][i] = 1'b0; known[1][i] = 1'b0;
         ref_mem[0][i] = 8'h00; ref_mem[1][i] = 8'h00;
      end
      exp_dout[0] = 8'h00;
      exp_dout[1] = 8'h00;

      tbl[0] = '{MRW_WRITE, 8'h10, 8'hA5, 8'h00};
      tbl[1] = '{MRW_READ,  8'h10, 8'h00, 8'hA5};
      tbl[2] = '{MRW_WRITE, 8'h11, 8'h5A, 8'hA5};
      tbl[3] = '{MRW_READ,  8'h11, 8'h00, 8'h5A};
      tbl[4] = '{MRW_WRITE, 8'h00, 8'h01, 8'h5A};
      tbl[5] = '{MRW_READ,  8'h10, 8'h00, 8'hA5};

      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      reset0 = 1'b1;
      reset1 = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy0), 32'd0);
      checkOutput("reset_ready", 32'(ready0), 32'd0);
      checkOutput("reset_dout", 32'(dout0), 32'd0);
      checkOutput("reset_busy_w1", 32'(busy1), 32'd0);
      reset0 = 1'b0;
      reset1 = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, tbl[i].rw, tbl[i].addr, tbl[i].data, 0, 0);
         checkOutput("table_dout", 32'(dout0), 32'(tbl[i].exp_dout));
         @(negedge clk);
      end

      $display("[TB] strobe ignored during read");
      applyStimulus(0, MRW_READ, 8'h10, 8'h00, 2, 0);
      repeat (W0 + 2) begin
         @(negedge clk);
         checkOutput("no_second_access", 32'(busy0), 32'd0);
      end

      $display("[TB] reset aborts write");
      applyStimulus(0, MRW_WRITE, 8'h20, 8'h77, 0, 0);
      applyStimulus(0, MRW_WRITE, 8'h20, 8'h3C, 0, 3);
      ref_mem[0][8'h20] = 8'h77;
      applyStimulus(0, MRW_READ, 8'h20, 8'h00, 0, 0);
      checkOutput("abort_keeps_old", 32'(dout0), 32'h77);

      $display("[TB] reset with strobe");
      drive(0, 1'b1, MRW_WRITE, 8'h10, 8'hEE);
      reset0 = 1'b1;
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      reset0 = 1'b0;
      exp_dout[0] = 8'h00;
      checkOutput("strobe_under_reset", 32'(busy0), 32'd0);
      @(negedge clk);
      checkOutput("strobe_under_reset_next", 32'(busy0), 32'd0);
      applyStimulus(0, MRW_READ, 8'h10, 8'h00, 0, 0);
      checkOutput("strobe_under_reset_mem", 32'(dout0), 32'hA5);

      $display("[TB] back-to-back write then read");
      applyStimulus(0, MRW_WRITE, 8'h30, 8'h12, 0, 0);
      applyStimulus(0, MRW_READ, 8'h30, 8'h00, 0, 0);
      checkOutput("b2b_read_new", 32'(dout0), 32'h12);

      $display("[TB] randomized accesses");
      for (int n = 0; n < 40; n++) begin
         a   = 8'($urandom);
         r_w = known[0][a] ? 1'($urandom_range(0, 1)) : MRW_WRITE;
         extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W0)) : 0;
         applyStimulus(0, r_w, a, 8'($urandom), extra, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] single wait state instance");
      applyStimulus(1, MRW_WRITE, 8'hFF, 8'hFF, 0, 0);
      applyStimulus(1, MRW_READ, 8'hFF, 8'h00, 0, 0);
      checkOutput("w1_read_ff", 32'(dout1), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, memory word width in bits.
REQ-003 SHALL have parameter WAIT_CYCLES, default 4, access wait states; legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MStrobe  input  1  access request, one-cycle pulse from cache controller.
REQ-007 SHALL have port MRW  input  1  access direction, 0 = read, 1 = write.
REQ-008 SHALL have port MAddr  input  ADDR_W  word address.
REQ-009 SHALL have port MDataIn  input  DATA_W  write data.
REQ-010 SHALL have port MDataOut  output  DATA_W  read data, registered.
REQ-011 SHALL have port MReady  output  1  one-cycle completion pulse, read or write.
REQ-012 SHALL have port MBusy  output  1  high while an access is in progress.

Function
REQ-013 SHALL hold a storage array of 2**ADDR_W words of DATA_W bits.
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 SHALL, in IDLE with MStrobe=1 at edge T, capture MRW, MAddr and MDataIn, load the wait counter with WAIT_CYCLES, and enter ACCESS.
REQ-016 SHALL, in IDLE with MStrobe=0, remain in IDLE.
REQ-017 SHALL, in ACCESS, decrement the counter by 1 per cycle and enter DONE on the edge where the counter equals 1.
REQ-018 SHALL spend exactly WAIT_CYCLES cycles in ACCESS, so MReady is high in cycle T+WAIT_CYCLES+1, with the strobe sampled in cycle T.
REQ-019 SHALL, for a captured write, commit the captured data to the captured address on the edge entering DONE.
REQ-020 SHALL, for a captured read, load MDataOut from the captured address on the edge entering DONE.
REQ-021 SHALL hold MDataOut unchanged from that point until the next read completes; writes never change MDataOut.
REQ-022 SHALL assert MReady only in DONE, and return DONE to IDLE unconditionally after one cycle.
REQ-023 SHALL drive MBusy high in ACCESS and DONE, and low in IDLE.
REQ-024 SHALL ignore MStrobe in ACCESS and DONE (no queueing); the captured request is unaffected by input changes after capture.
REQ-025 SHALL accept a new strobe in the first IDLE cycle after DONE, with no dead cycle.
REQ-026 SHALL, on a read of an address written by the immediately preceding access, return the newly written data.
REQ-027 SHALL use address wrap-free indexing; all 2**ADDR_W addresses are valid, with no out-of-range case.

Reset
REQ-028 SHALL, while reset=1 at an edge, force state IDLE, counter 0, MReady 0, MBusy 0, MDataOut 0, and clear the captured request registers to 0.
REQ-029 SHALL, on reset in ACCESS, abort the access; a pending write is not committed.
REQ-030 SHALL, on reset in the cycle a strobe is presented, ignore that strobe.
REQ-031 SHALL leave the storage array contents unaffected by reset.

Structure
REQ-032 SHALL take from shared package mem_pkg: the state enum (IDLE/ACCESS/DONE), MRW_READ=0 and MRW_WRITE=1 constants, and default width and wait constants.
REQ-033 SHALL place the loadable down-counter in sub-module mem_wait_ctr, with ports clk, reset, load, load_val[7:0] and last (counter==1).
REQ-034 SHALL keep the FSM, capture registers and storage array in main_mem_responder.

Verification
REQ-035 SHALL cover: write 0xA5 to 0x10 (strobe cycle 0) -> MReady=1 only in cycle 5, MBusy=1 in cycles 1-5, MDataOut unchanged.
REQ-036 SHALL cover: read 0x10 after that write -> MReady in cycle T+5, MDataOut=0xA5 from that cycle until the next read completes.
REQ-037 SHALL cover: MStrobe pulsed again in cycle T+2 during a read -> ignored, exactly one MReady, no second access.
REQ-038 SHALL cover: reset at T+3 of a write of 0x3C to 0x20 -> MBusy=0 and MReady=0 next cycle, later read of 0x20 returns the prior value.
REQ-039 SHALL cover: back-to-back accesses, with a strobe in the first IDLE cycle after DONE -> accepted, second MReady exactly WAIT_CYCLES+1 cycles after that strobe.
REQ-040 SHALL cover: WAIT_CYCLES=1, write 0xFF to address 0xFF then read it -> MReady at T+2 for each access, read returns 0xFF.
